// File: rtl/gpu_fb_pkg.sv
// Shared types and constants for the framebuffer writer.
// Contents: pixel_t bus payload, default framebuffer geometry, writer FSM state enum.
package gpu_fb_pkg;

    localparam int unsigned FB_W_DEF = 640;
    localparam int unsigned FB_H_DEF = 480;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned DATA_W   = 24;

    // One rasterised pixel as carried through the FIFO
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fb_state_t;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Synchronous pixel FIFO, DEPTH entries (power of two).
// Ports: clk, n_rst (async active-low), i_push/i_data write side, i_pop/o_data read side
// (o_data shows the head combinationally), o_full, o_empty, o_count occupancy.
// A push while full or a pop while empty is ignored.
module gpu_pixel_fifo
    import gpu_fb_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_push,
    input  pixel_t                   i_data,
    input  logic                     i_pop,
    output pixel_t                   o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    pixel_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_fb_writer.sv
// Framebuffer writer: buffers rasteriser pixels and turns each into a req/ack memory write
// at linear address y*FB_W + x (wraps mod 2^19) with data {r,g,b}.
// Ports: clk, n_rst (async active-low); pixel_valid_i/x_i/y_i/r_i/g_i/b_i/pixel_ready_o pixel
// input; mem_req_o/mem_addr_o/mem_wdata_o/mem_ack_i memory port; busy_o, fifo_count_o,
// clip_count_o status.
// Build option: define GPU_FB_CLIP_EN to discard pixels outside FB_W x FB_H and count them
// in clip_count_o; otherwise every pixel is written and clip_count_o is 0.
module gpu_fb_writer
    import gpu_fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FB_W       = FB_W_DEF,
    parameter int unsigned FB_H       = FB_H_DEF
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           pixel_valid_i,
    input  logic [9:0]                     x_i,
    input  logic [8:0]                     y_i,
    input  logic [7:0]                     r_i,
    input  logic [7:0]                     g_i,
    input  logic [7:0]                     b_i,
    output logic                           pixel_ready_o,
    output logic                           mem_req_o,
    output logic [18:0]                    mem_addr_o,
    output logic [23:0]                    mem_wdata_o,
    input  logic                           mem_ack_i,
    output logic                           busy_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o,
    output logic [15:0]                    clip_count_o
);

    fb_state_t           r_state;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    pixel_t              w_in;
    pixel_t              w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic                w_oob;
    logic                w_clip;
    logic [ADDR_W-1:0]   w_addr;

`ifdef GPU_FB_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    assign w_in = '{x: x_i, y: y_i, r: r_i, g: g_i, b: b_i};

    // No push when full, even if the FSM pops in the same cycle
    assign w_push = pixel_valid_i && !w_full;

    gpu_pixel_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count_o)
    );

    // Linear address of the FIFO head; the 640 case avoids a multiplier
    always_comb begin
        w_addr = '0;
        if (FB_W == 640) begin
            w_addr = (ADDR_W'(w_head.y) << 9) + (ADDR_W'(w_head.y) << 7) + ADDR_W'(w_head.x);
        end else begin
            w_addr = ADDR_W'((32'(w_head.y) * 32'(FB_W)) + 32'(w_head.x));
        end
    end

    assign w_oob  = (32'(w_head.x) >= FB_W) || (32'(w_head.y) >= FB_H);
    assign w_clip = CLIP_EN && w_oob;

    // Head is consumed when idle, or in the cycle the outstanding write is acked
    assign w_pop   = !w_empty && ((r_state == IDLE) || mem_ack_i);
    assign w_issue = w_pop && !w_clip;

    // Writer FSM: holding registers double as the memory port outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_addr  <= w_addr;
                        r_wdata <= {w_head.r, w_head.g, w_head.b};
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        if (w_issue) begin
                            r_addr  <= w_addr;
                            r_wdata <= {w_head.r, w_head.g, w_head.b};
                        end else begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef GPU_FB_CLIP_EN
    logic [15:0] r_clip_cnt;

    // Saturating count of discarded pixels
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_clip_cnt <= '0;
        end else if (w_pop && w_clip && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end

    assign clip_count_o = r_clip_cnt;
`else
    assign clip_count_o = 16'd0;
`endif

    assign pixel_ready_o = !w_full;
    assign mem_req_o     = r_req;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign busy_o        = (fifo_count_o != '0) || r_req;

endmodule

// File: tb/tb_gpu_fb_writer.sv
// Directed self-checking bench for gpu_fb_writer (FIFO_DEPTH=8, 640x480).
module tb_gpu_fb_writer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        pixel_valid_i = 1'b0;
    logic [9:0]  x_i = '0;
    logic [8:0]  y_i = '0;
    logic [7:0]  r_i = '0;
    logic [7:0]  g_i = '0;
    logic [7:0]  b_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        pixel_ready_o;
    logic        mem_req_o;
    logic [18:0] mem_addr_o;
    logic [23:0] mem_wdata_o;
    logic        busy_o;
    logic [3:0]  fifo_count_o;
    logic [15:0] clip_count_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [18:0] a;
        logic [23:0] d;
        int          c;
    } wr_t;
    wr_t wlog[$];

    gpu_fb_writer #(
        .FIFO_DEPTH    (8),
        .FB_W          (640),
        .FB_H          (480)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .pixel_valid_i (pixel_valid_i),
        .x_i           (x_i),
        .y_i           (y_i),
        .r_i           (r_i),
        .g_i           (g_i),
        .b_i           (b_i),
        .pixel_ready_o (pixel_ready_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .busy_o        (busy_o),
        .fifo_count_o  (fifo_count_o),
        .clip_count_o  (clip_count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A handshake seen at the falling edge completes at the following rising edge
    always @(negedge clk) begin
        if (n_rst && mem_req_o && mem_ack_i) begin
            wlog.push_back('{mem_addr_o, mem_wdata_o, cyc});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int x, input int y, input logic [23:0] rgb);
        x_i = 10'(x);
        y_i = 9'(y);
        {r_i, g_i, b_i} = rgb;
    endtask

    // Hold one pixel until accepted (bounded); ok reports acceptance
    task automatic send_pix(input int x, input int y, input logic [23:0] rgb, output bit ok);
        drive_pix(x, y, rgb);
        pixel_valid_i = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            ok = pixel_ready_o;
            tick();
        end
        pixel_valid_i = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int t = 0; t < budget && wlog.size() < n; t++) tick();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 19'd0 || mem_wdata_o !== 24'd0) begin
            $display("FAIL reset_port: req=%b addr=%0d wdata=%h expected 0/0/0",
                     mem_req_o, mem_addr_o, mem_wdata_o);
            errors++;
        end
        checks++;
        if (busy_o !== 1'b0 || fifo_count_o !== 4'd0 || clip_count_o !== 16'd0) begin
            $display("FAIL reset_status: busy=%b count=%0d clip=%0d expected 0/0/0",
                     busy_o, fifo_count_o, clip_count_o);
            errors++;
        end
        repeat (3) tick();
        n_rst = 1'b1;
        tick();
        checks++;
        if (pixel_ready_o !== 1'b1) begin
            $display("FAIL reset_ready: got %b expected 1", pixel_ready_o);
            errors++;
        end
    endtask

    task automatic test_single();
        mem_ack_i = 1'b1;
        wlog.delete();
        drive_pix(3, 2, 24'hFF8000);
        pixel_valid_i = 1'b1;
        tick();
        pixel_valid_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || fifo_count_o !== 4'd1) begin
            $display("FAIL single_push: req=%b count=%0d expected 0/1", mem_req_o, fifo_count_o);
            errors++;
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 19'd1283 || mem_wdata_o !== 24'hFF8000) begin
            $display("FAIL single_req: req=%b addr=%0d wdata=%h expected 1/1283/ff8000",
                     mem_req_o, mem_addr_o, mem_wdata_o);
            errors++;
        end
        tick();
        checks++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || wlog.size() != 1) begin
            $display("FAIL single_done: req=%b busy=%b writes=%0d expected 0/0/1",
                     mem_req_o, busy_o, wlog.size());
            errors++;
        end
    endtask

    task automatic test_burst();
        bit          stable;
        logic [23:0] exp_d;
        mem_ack_i = 1'b0;
        wlog.delete();
        // One pixel moves to the holding registers, eight more fill the FIFO
        for (int i = 0; i < 9; i++) begin
            drive_pix(i * 10 + 1, i, {8'(i), 8'hA5, ~8'(i)});
            pixel_valid_i = 1'b1;
            tick();
        end
        checks++;
        if (fifo_count_o !== 4'd8 || pixel_ready_o !== 1'b0) begin
            $display("FAIL burst_full: count=%0d ready=%b expected 8/0", fifo_count_o, pixel_ready_o);
            errors++;
        end
        drive_pix(500, 300, 24'h123456);
        stable = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (mem_req_o !== 1'b1 || mem_addr_o !== 19'd1 || mem_wdata_o !== 24'h00A5FF)
                stable = 1'b0;
        end
        pixel_valid_i = 1'b0;
        checks++;
        if (!stable) begin
            $display("FAIL burst_hold: addr=%0d wdata=%h req=%b expected 1/00a5ff/1",
                     mem_addr_o, mem_wdata_o, mem_req_o);
            errors++;
        end
        checks++;
        if (fifo_count_o !== 4'd8 || pixel_ready_o !== 1'b0) begin
            $display("FAIL burst_nopush: count=%0d ready=%b expected 8/0", fifo_count_o, pixel_ready_o);
            errors++;
        end
        mem_ack_i = 1'b1;
        wait_writes(9, 40);
        repeat (4) tick();
        checks++;
        if (wlog.size() != 9 || busy_o !== 1'b0) begin
            $display("FAIL burst_count: writes=%0d busy=%b expected 9/0", wlog.size(), busy_o);
            errors++;
        end
        for (int i = 0; i < 9 && i < wlog.size(); i++) begin
            exp_d = {8'(i), 8'hA5, ~8'(i)};
            checks++;
            if (wlog[i].a !== 19'(i * 640 + i * 10 + 1) || wlog[i].d !== exp_d ||
                wlog[i].c != wlog[0].c + i) begin
                $display("FAIL burst_write%0d: addr=%0d wdata=%h cyc=+%0d expected %0d/%h/+%0d",
                         i, wlog[i].a, wlog[i].d, wlog[i].c - wlog[0].c,
                         i * 640 + i * 10 + 1, exp_d, i);
                errors++;
            end
        end
    endtask

    task automatic test_ack3();
        logic [23:0] exp_d;
        mem_ack_i = 1'b0;
        wlog.delete();
        fork
            begin
                bit acc;
                for (int i = 0; i < 12; i++) begin
                    drive_pix(100 + i, 10 + i, {8'(i * 3), 8'(i * 5), 8'(i * 7)});
                    pixel_valid_i = 1'b1;
                    acc = 1'b0;
                    for (int t = 0; t < 60 && !acc; t++) begin
                        acc = pixel_ready_o;
                        tick();
                    end
                end
                pixel_valid_i = 1'b0;
            end
            begin
                for (int t = 0; t < 300 && wlog.size() < 12; t++) begin
                    mem_ack_i = ((t % 3) == 2);
                    tick();
                end
                mem_ack_i = 1'b0;
            end
        join
        mem_ack_i = 1'b1;
        repeat (6) tick();
        checks++;
        if (wlog.size() != 12 || busy_o !== 1'b0) begin
            $display("FAIL ack3_count: writes=%0d busy=%b expected 12/0", wlog.size(), busy_o);
            errors++;
        end
        for (int i = 0; i < 12 && i < wlog.size(); i++) begin
            exp_d = {8'(i * 3), 8'(i * 5), 8'(i * 7)};
            checks++;
            if (wlog[i].a !== 19'((10 + i) * 640 + 100 + i) || wlog[i].d !== exp_d) begin
                $display("FAIL ack3_write%0d: addr=%0d wdata=%h expected %0d/%h",
                         i, wlog[i].a, wlog[i].d, (10 + i) * 640 + 100 + i, exp_d);
                errors++;
            end
        end
    endtask

    task automatic test_corners();
        bit ok0, ok1;
        mem_ack_i = 1'b1;
        wlog.delete();
        send_pix(639, 479, 24'h123456, ok0);
        send_pix(0, 0, 24'hABCDEF, ok1);
        wait_writes(2, 20);
        repeat (3) tick();
        checks++;
        if (!ok0 || !ok1 || wlog.size() != 2) begin
            $display("FAIL corner_count: accepted=%b%b writes=%0d expected 11/2", ok0, ok1, wlog.size());
            errors++;
        end
        if (wlog.size() == 2) begin
            checks++;
            if (wlog[0].a !== 19'd307199 || wlog[0].d !== 24'h123456) begin
                $display("FAIL corner_max: addr=%0d wdata=%h expected 307199/123456",
                         wlog[0].a, wlog[0].d);
                errors++;
            end
            checks++;
            if (wlog[1].a !== 19'd0 || wlog[1].d !== 24'hABCDEF) begin
                $display("FAIL corner_zero: addr=%0d wdata=%h expected 0/abcdef",
                         wlog[1].a, wlog[1].d);
                errors++;
            end
        end
    endtask

    task automatic test_clip();
        bit          ok;
        int          n_exp;
        logic [18:0] exp_a [4];
        logic [23:0] exp_d [4];
        logic [15:0] exp_clip;
`ifdef GPU_FB_CLIP_EN
        n_exp = 2;
        exp_a[0] = 19'd3205;  exp_d[0] = 24'h010203;
        exp_a[1] = 19'd3846;  exp_d[1] = 24'h070809;
        exp_a[2] = 19'd0;     exp_d[2] = 24'h0;
        exp_a[3] = 19'd0;     exp_d[3] = 24'h0;
        exp_clip = 16'd2;
`else
        n_exp = 4;
        exp_a[0] = 19'd3205;   exp_d[0] = 24'h010203;
        exp_a[1] = 19'd640;    exp_d[1] = 24'h040506;
        exp_a[2] = 19'd3846;   exp_d[2] = 24'h070809;
        exp_a[3] = 19'd307200; exp_d[3] = 24'h0A0B0C;
        exp_clip = 16'd0;
`endif
        mem_ack_i = 1'b1;
        wlog.delete();
        send_pix(5, 5, 24'h010203, ok);
        send_pix(640, 0, 24'h040506, ok);
        send_pix(6, 6, 24'h070809, ok);
        send_pix(0, 480, 24'h0A0B0C, ok);
        repeat (10) tick();
        checks++;
        if (wlog.size() != n_exp || clip_count_o !== exp_clip || busy_o !== 1'b0) begin
            $display("FAIL clip_count: writes=%0d clip=%0d busy=%b expected %0d/%0d/0",
                     wlog.size(), clip_count_o, busy_o, n_exp, exp_clip);
            errors++;
        end
        for (int i = 0; i < n_exp && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i].a !== exp_a[i] || wlog[i].d !== exp_d[i]) begin
                $display("FAIL clip_write%0d: addr=%0d wdata=%h expected %0d/%h",
                         i, wlog[i].a, wlog[i].d, exp_a[i], exp_d[i]);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid();
        mem_ack_i = 1'b0;
        wlog.delete();
        for (int i = 0; i < 5; i++) begin
            drive_pix(20 + i, 1, 24'h5A5A00 + 24'(i));
            pixel_valid_i = 1'b1;
            tick();
        end
        pixel_valid_i = 1'b0;
        checks++;
        if (fifo_count_o !== 4'd4 || mem_req_o !== 1'b1) begin
            $display("FAIL rstmid_pre: count=%0d req=%b expected 4/1", fifo_count_o, mem_req_o);
            errors++;
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || fifo_count_o !== 4'd0 || busy_o !== 1'b0 || mem_addr_o !== 19'd0) begin
            $display("FAIL rstmid_async: req=%b count=%0d busy=%b addr=%0d expected 0/0/0/0",
                     mem_req_o, fifo_count_o, busy_o, mem_addr_o);
            errors++;
        end
        repeat (2) tick();
        mem_ack_i = 1'b1;
        n_rst = 1'b1;
        repeat (10) tick();
        checks++;
        if (wlog.size() != 0 || mem_req_o !== 1'b0 || pixel_ready_o !== 1'b1) begin
            $display("FAIL rstmid_stale: writes=%0d req=%b ready=%b expected 0/0/1",
                     wlog.size(), mem_req_o, pixel_ready_o);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_ack3();
        test_corners();
        test_clip();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
